lvds_rx_word_aligner: RTL and testbench
=======================================

// Module: lvds_rx_word_aligner
// PURPOSE
//  Downstream of the LVDS init sequencer. Once that sequencer signals init done, it word-aligns the deserialised RX
//  parallel data to a known training word by pulsing rx_bitslip. It reports aligned/failed status and requests an
//  interface re-init (retry) from the init sequencer when every rotation fails.
// PARAMETERS
//  DESER_FACTOR   10         deserialisation factor; rx_data width and number of distinct rotations
//  TRAIN_PATTERN  10'h3E0    training word expected on rx_data when aligned (DESER_FACTOR bits)
//  SLIP_SETTLE    4          cycles waited after start/bitslip before sampling rx_data (>=1)
//  MATCH_COUNT    16         consecutive matching words required to declare alignment (>=1)
//  MAX_RETRY      3          interface re-init requests issued before giving up (>=0)
// PORTS
//  clk              in   1             core/parallel clock
//  srst             in   1             synchronous reset, active-high
//  init_done        in   1             1-cycle pulse from init sequencer: interface ready, start alignment
//  rx_data          in   DESER_FACTOR  deserialised word, one per clk
//  rx_bitslip       out  1             1-cycle pulse: rotate deserialiser by one bit
//  aligned          out  1             level: alignment achieved
//  align_fail       out  1             level: all rotations and all retries exhausted
//  interface_rst    out  1             1-cycle pulse: request init sequencer re-run
//  slip_count       out  $clog2(DESER_FACTOR+1)  [ALIGN_STATUS_EN only] slips issued in current attempt
//  retry_count      out  $clog2(MAX_RETRY+1)     [ALIGN_STATUS_EN only] retries issued since srst/alignment
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (srst). srst dominates all inputs.
//  - Reset: state IDLE; all outputs 0; slip_cnt, match_cnt, settle_cnt, retry_cnt all 0.
//  - All outputs are registered (Moore); no combinational path from inputs to outputs.
//  - FSM states: IDLE, SETTLE, CHECK, SLIP, ALIGNED, RETRY, FAIL.
//  - IDLE:    init_done=1 -> SETTLE, settle_cnt<=SLIP_SETTLE, slip_cnt<=0.
//  - SETTLE:  settle_cnt decrements each cycle; when settle_cnt==1 -> CHECK, match_cnt<=0.
//             SETTLE lasts exactly SLIP_SETTLE cycles.
//  - CHECK:   rx_data==TRAIN_PATTERN -> match_cnt++. The MATCH_COUNT-th consecutive match -> ALIGNED, retry_cnt<=0.
//             Mismatch: if slip_cnt<DESER_FACTOR-1 -> SLIP; otherwise (all rotations tried) -> RETRY.
//             Every mismatch clears match_cnt.
//  - SLIP:    rx_bitslip=1 for this single cycle; slip_cnt++; -> SETTLE with settle_cnt<=SLIP_SETTLE.
//  - RETRY:   retry_cnt<MAX_RETRY -> interface_rst=1 for one cycle, retry_cnt++, -> IDLE.
//             Otherwise -> FAIL, with no interface_rst pulse.
//  - ALIGNED: aligned=1 and held. init_done -> SETTLE (full re-alignment, slip_cnt<=0); aligned drops the next cycle.
//  - FAIL:    align_fail=1 and held. init_done -> SETTLE, slip_cnt<=0, retry_cnt<=0; align_fail drops next cycle.
//  - init_done in SETTLE/CHECK/SLIP/RETRY is ignored.
//  - Latency, immediate match: init_done sampled at edge 0 -> aligned high after edge 1+SLIP_SETTLE+MATCH_COUNT
//    (21 with defaults).
//  - Each slip adds 1+SLIP_SETTLE cycles plus the cycles spent in CHECK up to and including the mismatch.
//  - At most DESER_FACTOR-1 rx_bitslip pulses per attempt; rx_bitslip pulses never occur on consecutive cycles.
//  - aligned and align_fail are never both 1. interface_rst is never asserted while aligned=1.
//  - srst mid-sequence: outputs 0 on the next cycle; any pending slip/retry is abandoned; counters are cleared.
// CONFIGURATION
//  - ALIGN_STATUS_EN defined: slip_count and retry_count ports exist, driven from slip_cnt/retry_cnt registers;
//    both are 0 in reset.
//  - ALIGN_STATUS_EN undefined: those ports are absent; the FSM and all other ports are cycle-identical.
// TESTING
//  - Immediate lock: init_done at cycle 0, rx_data=10'h3E0 always -> no rx_bitslip; aligned=1 from cycle 21.
//  - 3-bit skew: bench rotates the pattern by 1 bit per rx_bitslip, starting 3 rotations off
//    -> exactly 3 rx_bitslip pulses, each >=5 cycles apart, then aligned=1.
//  - Glitch: 15 matches, 1 mismatch, then matches -> match_cnt restarts, one rx_bitslip issued;
//    the aligned rise is delayed accordingly.
//  - Never matches, MAX_RETRY=3: 9 slips per attempt, 3 interface_rst pulses each followed by init_done replay
//    -> 4th exhaustion gives align_fail=1, no further pulses.
//  - srst asserted mid-CHECK after 2 slips -> all outputs 0 next cycle; subsequent init_done restarts with slip_cnt=0.
//  - init_done while ALIGNED -> aligned=0 next cycle, re-alignment completes; init_done during SETTLE has no effect.

Source files
------------

// File: rtl/lvds_rx_word_aligner_if.sv
// Bus between the LVDS word aligner and its environment (init sequencer, deserialiser).
// Optional status signals slip_count/retry_count exist only when ALIGN_STATUS_EN is defined.
interface lvds_rx_word_aligner_if #(
    parameter int unsigned DESER_FACTOR = 10
`ifdef ALIGN_STATUS_EN
    , parameter int unsigned MAX_RETRY = 3
`endif
);
    logic                    init_done;
    logic [DESER_FACTOR-1:0] rx_data;
    logic                    rx_bitslip;
    logic                    aligned;
    logic                    align_fail;
    logic                    interface_rst;
`ifdef ALIGN_STATUS_EN
    localparam int unsigned SLIP_W  = $clog2(DESER_FACTOR + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [SLIP_W-1:0]       slip_count;
    logic [RETRY_W-1:0]      retry_count;
`endif

    modport master (
        output init_done, rx_data,
        input  rx_bitslip, aligned, align_fail, interface_rst
`ifdef ALIGN_STATUS_EN
        , input slip_count, retry_count
`endif
    );

    modport slave (
        input  init_done, rx_data,
        output rx_bitslip, aligned, align_fail, interface_rst
`ifdef ALIGN_STATUS_EN
        , output slip_count, retry_count
`endif
    );
endinterface

// File: rtl/lvds_rx_word_aligner.sv
// Word-aligns deserialised LVDS data to a training word by bitslipping, with interface re-init retries.
// Define ALIGN_STATUS_EN to expose slip_count/retry_count on the bus.
module lvds_rx_word_aligner #(
    parameter int unsigned            DESER_FACTOR  = 10,
    parameter logic [DESER_FACTOR-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter int unsigned            SLIP_SETTLE   = 4,
    parameter int unsigned            MATCH_COUNT   = 16,
    parameter int unsigned            MAX_RETRY     = 3
) (
    input logic                   clk,
    input logic                   srst,
    lvds_rx_word_aligner_if.slave bus
);
    localparam int unsigned SLIP_W   = $clog2(DESER_FACTOR + 1);
    localparam int unsigned SETTLE_W = $clog2(SLIP_SETTLE + 1);
    localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(DESER_FACTOR - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SLIP_SETTLE);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        ALIGNED,
        RETRY,
        FAIL
    } state_t;

    state_t              state, state_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_n;
    logic [SLIP_W-1:0]   slip_cnt, slip_n;
    logic [MATCH_W-1:0]  match_cnt, match_n;
    logic [RETRY_W-1:0]  retry_cnt, retry_n;

    logic                rx_bitslip_q;
    logic                aligned_q;
    logic                fail_q;
    logic                interface_rst_q;
    logic                pattern_hit;
    logic                retry_left;

    assign pattern_hit = (bus.rx_data == TRAIN_PATTERN);
    assign retry_left  = (retry_cnt < RETRY_MAX);

    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            slip_cnt        <= '0;
            match_cnt       <= '0;
            retry_cnt       <= '0;
            rx_bitslip_q    <= 1'b0;
            aligned_q       <= 1'b0;
            fail_q          <= 1'b0;
            interface_rst_q <= 1'b0;
        end else begin
            state           <= state_n;
            settle_cnt      <= settle_n;
            slip_cnt        <= slip_n;
            match_cnt       <= match_n;
            retry_cnt       <= retry_n;
            // Outputs are registered images of the current state, one cycle behind it.
            rx_bitslip_q    <= (state == SLIP);
            aligned_q       <= (state == ALIGNED);
            fail_q          <= (state == FAIL);
            interface_rst_q <= (state == RETRY) && retry_left;
        end
    end

    always_comb begin
        state_n  = state;
        settle_n = settle_cnt;
        slip_n   = slip_cnt;
        match_n  = match_cnt;
        retry_n  = retry_cnt;
        unique case (state)
            IDLE: begin
                if (bus.init_done) begin
                    state_n  = SETTLE;
                    settle_n = SETTLE_LOAD;
                    slip_n   = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_W'(1)) begin
                    state_n = CHECK;
                    match_n = '0;
                end else begin
                    settle_n = settle_cnt - SETTLE_W'(1);
                end
            end
            CHECK: begin
                if (pattern_hit) begin
                    match_n = match_cnt + MATCH_W'(1);
                    if (match_cnt == MATCH_LAST) begin
                        state_n = ALIGNED;
                        retry_n = '0;
                    end
                end else begin
                    match_n = '0;
                    state_n = (slip_cnt < SLIP_LAST) ? SLIP : RETRY;
                end
            end
            SLIP: begin
                slip_n   = slip_cnt + SLIP_W'(1);
                settle_n = SETTLE_LOAD;
                state_n  = SETTLE;
            end
            RETRY: begin
                if (retry_left) begin
                    retry_n = retry_cnt + RETRY_W'(1);
                    state_n = IDLE;
                end else begin
                    state_n = FAIL;
                end
            end
            ALIGNED: begin
                if (bus.init_done) begin
                    state_n  = SETTLE;
                    settle_n = SETTLE_LOAD;
                    slip_n   = '0;
                end
            end
            FAIL: begin
                if (bus.init_done) begin
                    state_n  = SETTLE;
                    settle_n = SETTLE_LOAD;
                    slip_n   = '0;
                    retry_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_bitslip    = rx_bitslip_q;
    assign bus.aligned       = aligned_q;
    assign bus.align_fail    = fail_q;
    assign bus.interface_rst = interface_rst_q;
`ifdef ALIGN_STATUS_EN
    assign bus.slip_count    = slip_cnt;
    assign bus.retry_count   = retry_cnt;
`endif

    assert property (@(posedge clk) disable iff (srst) !(aligned_q && fail_q));
    assert property (@(posedge clk) disable iff (srst) rx_bitslip_q |=> !rx_bitslip_q);
    assert property (@(posedge clk) disable iff (srst) !(interface_rst_q && aligned_q));
endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed self-checking bench for lvds_rx_word_aligner; edge e counts from the edge that samples init_done.
// Extra status checks compile in when ALIGN_STATUS_EN is defined.
module tb_lvds_rx_word_aligner;
    localparam int unsigned     DF    = 10;
    localparam logic [DF-1:0]   TRAIN = 10'h3E0;
    localparam int unsigned     SS    = 4;
    localparam int unsigned     MC    = 16;
    localparam int unsigned     MR    = 3;

    logic clk;
    logic srst;
    int   n_checks;
    int   n_fails;

    lvds_rx_word_aligner_if #(
        .DESER_FACTOR(DF)
`ifdef ALIGN_STATUS_EN
        , .MAX_RETRY(MR)
`endif
    ) bus ();

    lvds_rx_word_aligner #(
        .DESER_FACTOR (DF),
        .TRAIN_PATTERN(TRAIN),
        .SLIP_SETTLE  (SS),
        .MATCH_COUNT  (MC),
        .MAX_RETRY    (MR)
    ) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DF-1:0] rotl(input int unsigned r);
        logic [DF-1:0] p;
        p = TRAIN;
        for (int unsigned i = 0; i < r; i++) p = {p[DF-2:0], p[DF-1]};
        return p;
    endfunction

    task automatic apply_reset();
        srst          = 1'b1;
        bus.init_done = 1'b0;
        bus.rx_data   = '0;
        repeat (3) tick();
        srst = 1'b0;
        tick();
    endtask

    // Drives init_done at edge 0, models a deserialiser that rotates on each bitslip when follow=1,
    // and replays init_done after every interface_rst. Stops on aligned/align_fail or after max_edges.
    task automatic run_align(input int unsigned start_rot, input bit follow, input bit never,
                             input int glitch, input int max_edges,
                             output int slips, output int min_gap, output int rise,
                             output int irsts, output int fail_at, output int bad);
        int unsigned r;
        int          last_slip;
        bit          pend_init;
        r = start_rot; last_slip = -1000; pend_init = 1'b1;
        slips = 0; min_gap = 1000; rise = -1; irsts = 0; fail_at = -1; bad = 0;
        for (int e = 0; e < max_edges; e++) begin
            bus.init_done = pend_init;
            pend_init     = 1'b0;
            bus.rx_data   = (never || e == glitch) ? '0 : rotl(r);
            tick();
            if (bus.rx_bitslip) begin
                slips++;
                if (e - last_slip < min_gap) min_gap = e - last_slip;
                last_slip = e;
                if (follow) r = (r + DF - 1) % DF;
            end
            if (bus.interface_rst) begin
                irsts++;
                pend_init = 1'b1;
            end
            if (bus.aligned && bus.align_fail) bad++;
            if (bus.aligned && bus.interface_rst) bad++;
            if (bus.aligned) begin rise = e; break; end
            if (bus.align_fail) begin fail_at = e; break; end
        end
        bus.init_done = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; bus.init_done = 1'b1; bus.rx_data = TRAIN;
        repeat (4) tick();
        n_checks++; if (bus.rx_bitslip !== 1'b0) begin n_fails++; $display("FAIL reset_bitslip: got %b want 0", bus.rx_bitslip); end
        n_checks++; if (bus.aligned !== 1'b0) begin n_fails++; $display("FAIL reset_aligned: got %b want 0", bus.aligned); end
        n_checks++; if (bus.align_fail !== 1'b0) begin n_fails++; $display("FAIL reset_align_fail: got %b want 0", bus.align_fail); end
        n_checks++; if (bus.interface_rst !== 1'b0) begin n_fails++; $display("FAIL reset_interface_rst: got %b want 0", bus.interface_rst); end
`ifdef ALIGN_STATUS_EN
        n_checks++; if (bus.slip_count !== '0) begin n_fails++; $display("FAIL reset_slip_count: got %0d want 0", bus.slip_count); end
        n_checks++; if (bus.retry_count !== '0) begin n_fails++; $display("FAIL reset_retry_count: got %0d want 0", bus.retry_count); end
`endif
        bus.init_done = 1'b0;
        srst = 1'b0;
        tick();
    endtask

    task automatic test_immediate_lock();
        int s, g, rise, ir, fa, bad;
        apply_reset();
        run_align(0, 1'b1, 1'b0, -1, 100, s, g, rise, ir, fa, bad);
        n_checks++; if (rise !== 21) begin n_fails++; $display("FAIL immediate_rise: got %0d want 21", rise); end
        n_checks++; if (s !== 0) begin n_fails++; $display("FAIL immediate_slips: got %0d want 0", s); end
        n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL immediate_exclusive: got %0d want 0", bad); end
    endtask

    task automatic test_skew3();
        int s, g, rise, ir, fa, bad;
        apply_reset();
        run_align(3, 1'b1, 1'b0, -1, 200, s, g, rise, ir, fa, bad);
        n_checks++; if (s !== 3) begin n_fails++; $display("FAIL skew_slips: got %0d want 3", s); end
        n_checks++; if (g < 5) begin n_fails++; $display("FAIL skew_gap: got %0d want >=5", g); end
        n_checks++; if (rise !== 39) begin n_fails++; $display("FAIL skew_rise: got %0d want 39", rise); end
        n_checks++; if (ir !== 0) begin n_fails++; $display("FAIL skew_irst: got %0d want 0", ir); end
`ifdef ALIGN_STATUS_EN
        n_checks++; if (bus.slip_count !== 4'd3) begin n_fails++; $display("FAIL skew_slip_count: got %0d want 3", bus.slip_count); end
`endif
    endtask

    task automatic test_glitch();
        int s, g, rise, ir, fa, bad;
        apply_reset();
        // 15 matches on edges 5..19, mismatch sampled at edge 20
        run_align(0, 1'b0, 1'b0, 20, 200, s, g, rise, ir, fa, bad);
        n_checks++; if (s !== 1) begin n_fails++; $display("FAIL glitch_slips: got %0d want 1", s); end
        n_checks++; if (rise !== 42) begin n_fails++; $display("FAIL glitch_rise: got %0d want 42", rise); end
        n_checks++; if (ir !== 0) begin n_fails++; $display("FAIL glitch_irst: got %0d want 0", ir); end
    endtask

    task automatic test_never_match();
        int s, g, rise, ir, fa, bad;
        int extra;
        int drop_seen;
        int rise2;
        apply_reset();
        run_align(0, 1'b0, 1'b1, -1, 2000, s, g, rise, ir, fa, bad);
        n_checks++; if (s !== 36) begin n_fails++; $display("FAIL never_slips: got %0d want 36", s); end
        n_checks++; if (ir !== 3) begin n_fails++; $display("FAIL never_irst: got %0d want 3", ir); end
        n_checks++; if (fa !== 244) begin n_fails++; $display("FAIL never_fail_edge: got %0d want 244", fa); end
        n_checks++; if (rise !== -1 || bad !== 0) begin n_fails++; $display("FAIL never_aligned: rise %0d bad %0d want -1 0", rise, bad); end
`ifdef ALIGN_STATUS_EN
        n_checks++; if (bus.retry_count !== 2'd3) begin n_fails++; $display("FAIL never_retry_count: got %0d want 3", bus.retry_count); end
`endif
        extra = 0;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (bus.rx_bitslip || bus.interface_rst || !bus.align_fail || bus.aligned) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fails++; $display("FAIL never_held: got %0d bad cycles want 0", extra); end
        drop_seen = -1; rise2 = -1;
        for (int e = 0; e < 60; e++) begin
            bus.init_done = (e == 0);
            bus.rx_data   = TRAIN;
            tick();
            if (e == 1) drop_seen = bus.align_fail;
            if (bus.aligned && rise2 < 0) rise2 = e;
        end
        bus.init_done = 1'b0;
        n_checks++; if (drop_seen !== 0) begin n_fails++; $display("FAIL fail_recover_drop: got %0d want 0", drop_seen); end
        n_checks++; if (rise2 !== 21) begin n_fails++; $display("FAIL fail_recover_rise: got %0d want 21", rise2); end
    endtask

    task automatic test_srst_mid_check();
        int s, g, rise, ir, fa, bad;
        int extra;
        apply_reset();
        run_align(5, 1'b1, 1'b0, -1, 17, s, g, rise, ir, fa, bad);
        n_checks++; if (s !== 2) begin n_fails++; $display("FAIL srst_pre_slips: got %0d want 2", s); end
        srst = 1'b1;
        tick();
        n_checks++; if ({bus.rx_bitslip, bus.aligned, bus.align_fail, bus.interface_rst} !== 4'b0000) begin
            n_fails++; $display("FAIL srst_outputs: got %b want 0000", {bus.rx_bitslip, bus.aligned, bus.align_fail, bus.interface_rst});
        end
`ifdef ALIGN_STATUS_EN
        n_checks++; if (bus.slip_count !== '0) begin n_fails++; $display("FAIL srst_slip_count: got %0d want 0", bus.slip_count); end
`endif
        srst = 1'b0;
        extra = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (bus.rx_bitslip || bus.interface_rst || bus.aligned || bus.align_fail) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fails++; $display("FAIL srst_quiet: got %0d active cycles want 0", extra); end
        // 8 rotations off: only reachable without a retry if slip_cnt restarted at 0
        run_align(8, 1'b1, 1'b0, -1, 300, s, g, rise, ir, fa, bad);
        n_checks++; if (s !== 8) begin n_fails++; $display("FAIL srst_restart_slips: got %0d want 8", s); end
        n_checks++; if (ir !== 0) begin n_fails++; $display("FAIL srst_restart_irst: got %0d want 0", ir); end
        n_checks++; if (rise !== 69) begin n_fails++; $display("FAIL srst_restart_rise: got %0d want 69", rise); end
    endtask

    task automatic test_realign();
        int s, g, rise, ir, fa, bad;
        int a1, a20, a21;
        apply_reset();
        run_align(0, 1'b1, 1'b0, -1, 100, s, g, rise, ir, fa, bad);
        a1 = -1; a20 = -1; a21 = -1;
        for (int e = 0; e < 25; e++) begin
            bus.init_done = (e == 0 || e == 2);
            bus.rx_data   = TRAIN;
            tick();
            if (e == 1)  a1  = bus.aligned;
            if (e == 20) a20 = bus.aligned;
            if (e == 21) a21 = bus.aligned;
        end
        bus.init_done = 1'b0;
        n_checks++; if (a1 !== 0) begin n_fails++; $display("FAIL realign_drop: got %0d want 0", a1); end
        n_checks++; if (a20 !== 0) begin n_fails++; $display("FAIL realign_early: got %0d want 0", a20); end
        n_checks++; if (a21 !== 1) begin n_fails++; $display("FAIL realign_rise: got %0d want 1", a21); end
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        srst          = 1'b1;
        bus.init_done = 1'b0;
        bus.rx_data   = '0;
        test_reset();
        test_immediate_lock();
        test_skew3();
        test_glitch();
        test_never_match();
        test_srst_mid_check();
        test_realign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
